regs_scoreboard: RTL and testbench

- Issue-stage controller for the DLX 32x32 register file (2 synchronous read ports, 1 write port; a write to R0 is ignored).
- Tracks an outstanding-write bit per register and stalls issue on RAW/WAW hazards.
- Drives the register-file read addresses and flags operand validity one cycle after issue, matching the registered read latency.
- Provides a drain/quiesce sequence used before exception entry.

---
 rtl/regs_pkg.sv | 19 +
 rtl/regs_scoreboard_hazard_chk.sv | 55 +++++
 rtl/regs_scoreboard.sv | 163 ++++++++++++++++
 tb/tb_regs_scoreboard.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regs_pkg : shared types for the DLX register-file issue scoreboard          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package regs_pkg;

    localparam int NREGS = 32;

    typedef logic [4:0] reg_idx_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HELD  = 2'd2
    } sb_state_t;

endpackage : regs_pkg
`default_nettype wire

// File: rtl/regs_scoreboard_hazard_chk.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sb_hazard_chk : combinational RAW/WAW hazard and forward eligibility       |
// | Optional macro: REGS_SB_FWD_EN (same-cycle writeback forwarding)           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sb_hazard_chk
    import regs_pkg::*;
(
    input  logic [NREGS-1:0] i_pending,
    input  reg_idx_t         i_rs1,
    input  reg_idx_t         i_rs2,
    input  reg_idx_t         i_rd,
    input  logic             i_use1,
    input  logic             i_use2,
    input  logic             i_wr,
`ifdef REGS_SB_FWD_EN
    input  logic             i_wb_valid,
    input  reg_idx_t         i_wb_rd,
    output logic             o_fwd1,
    output logic             o_fwd2,
`endif
    output logic             o_haz
);

    logic w_src1;
    logic w_src2;
    logic w_dst;
    logic w_blk1;
    logic w_blk2;

    assign w_src1 = i_use1 & i_pending[i_rs1];
    assign w_src2 = i_use2 & i_pending[i_rs2];
    assign w_dst  = i_wr   & i_pending[i_rd];

`ifdef REGS_SB_FWD_EN
    logic w_hit1;
    logic w_hit2;

    // A source whose only blocker is this cycle's writeback can take the WB value.
    assign w_hit1 = i_wb_valid & (i_wb_rd == i_rs1) & (i_rs1 != 5'd0);
    assign w_hit2 = i_wb_valid & (i_wb_rd == i_rs2) & (i_rs2 != 5'd0);
    assign o_fwd1 = w_src1 & w_hit1;
    assign o_fwd2 = w_src2 & w_hit2;
    assign w_blk1 = w_src1 & ~w_hit1;
    assign w_blk2 = w_src2 & ~w_hit2;
`else
    assign w_blk1 = w_src1;
    assign w_blk2 = w_src2;
`endif

    assign o_haz = w_blk1 | w_blk2 | w_dst;

endmodule : sb_hazard_chk
`default_nettype wire

// File: rtl/regs_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regs_scoreboard : DLX issue-stage scoreboard with drain/quiesce control    |
// | Optional macro: REGS_SB_FWD_EN adds fwd1/fwd2 writeback-forward outputs    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module regs_scoreboard
    import regs_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iss_valid,
    output logic             iss_ready,
    input  reg_idx_t         iss_rs1,
    input  reg_idx_t         iss_rs2,
    input  reg_idx_t         iss_rd,
    input  logic             iss_use1,
    input  logic             iss_use2,
    input  logic             iss_wr,
    input  logic             wb_valid,
    input  reg_idx_t         wb_rd,
    output reg_idx_t         rf_rs1,
    output reg_idx_t         rf_rs2,
    output logic             op_valid,
    output logic [NREGS-1:0] pending,
    output logic [CNT_W-1:0] inflight,
    input  logic             drain_req,
    output logic             drained,
`ifdef REGS_SB_FWD_EN
    output logic             fwd1,
    output logic             fwd2,
`endif
    output logic             wb_err
);

    localparam logic [CNT_W-1:0] c_MAX = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);
    localparam logic [NREGS-1:0] c_BIT0 = NREGS'(1);

    sb_state_t        r_state;
    sb_state_t        w_state_nxt;
    logic [NREGS-1:0] r_pending;
    logic [CNT_W-1:0] r_inflight;
    logic             r_op_valid;
    logic             r_wb_err;

    logic             w_haz;
    logic             w_full;
    logic             w_accept;
    logic             w_set;
    logic             w_clr;
    logic             w_err;
    logic [NREGS-1:0] w_set_mask;
    logic [NREGS-1:0] w_clr_mask;

    // Read addresses go straight to the regfile; its registered read aligns with op_valid.
    assign rf_rs1 = iss_rs1;
    assign rf_rs2 = iss_rs2;

`ifdef REGS_SB_FWD_EN
    logic w_fwd1;
    logic w_fwd2;
    logic r_fwd1;
    logic r_fwd2;
`endif

    sb_hazard_chk u_hazard_chk (
        .i_pending  (r_pending),
        .i_rs1      (iss_rs1),
        .i_rs2      (iss_rs2),
        .i_rd       (iss_rd),
        .i_use1     (iss_use1),
        .i_use2     (iss_use2),
        .i_wr       (iss_wr),
`ifdef REGS_SB_FWD_EN
        .i_wb_valid (wb_valid),
        .i_wb_rd    (wb_rd),
        .o_fwd1     (w_fwd1),
        .o_fwd2     (w_fwd2),
`endif
        .o_haz      (w_haz)
    );

    assign w_full     = iss_wr & (iss_rd != 5'd0) & (r_inflight == c_MAX);
    assign w_accept   = iss_valid & iss_ready;
    assign w_set      = w_accept & iss_wr & (iss_rd != 5'd0);
    assign w_clr      = wb_valid & (wb_rd != 5'd0) & r_pending[wb_rd];
    assign w_err      = wb_valid & (wb_rd != 5'd0) & ~r_pending[wb_rd];
    assign w_set_mask = w_set ? (c_BIT0 << iss_rd) : '0;
    assign w_clr_mask = w_clr ? (c_BIT0 << wb_rd)  : '0;

    always_comb begin
        w_state_nxt = r_state;
        iss_ready   = 1'b0;
        drained     = 1'b0;
        case (r_state)
            RUN: begin
                iss_ready = ~rst & ~w_haz & ~w_full;
                if (drain_req) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (r_inflight == '0) begin
                    w_state_nxt = HELD;
                end
            end
            HELD: begin
                drained = 1'b1;
                if (!drain_req) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_pending  <= '0;
            r_inflight <= '0;
            r_op_valid <= 1'b0;
            r_wb_err   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            // Issue and writeback never target the same register: WAW blocks that issue.
            r_pending  <= (r_pending & ~w_clr_mask) | w_set_mask;
            r_op_valid <= w_accept;
            r_wb_err   <= w_err;
            case ({w_set, w_clr})
                2'b10:   r_inflight <= r_inflight + c_ONE;
                2'b01:   r_inflight <= r_inflight - c_ONE;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

`ifdef REGS_SB_FWD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fwd1 <= 1'b0;
            r_fwd2 <= 1'b0;
        end else begin
            r_fwd1 <= w_accept & w_fwd1;
            r_fwd2 <= w_accept & w_fwd2;
        end
    end

    assign fwd1 = r_fwd1;
    assign fwd2 = r_fwd2;
`endif

    assign pending  = r_pending;
    assign inflight = r_inflight;
    assign op_valid = r_op_valid;
    assign wb_err   = r_wb_err;

endmodule : regs_scoreboard
`default_nettype wire

// File: tb/tb_regs_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_regs_scoreboard : directed cycle-by-cycle vectors for regs_scoreboard   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_regs_scoreboard;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
`ifdef REGS_SB_FWD_EN
    localparam logic c_FWD = 1'b1;
`else
    localparam logic c_FWD = 1'b0;
`endif

    typedef struct packed {
        logic        rst;
        logic        iv;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        u1;
        logic        u2;
        logic        wr;
        logic        wbv;
        logic [4:0]  wbrd;
        logic        drq;
        logic        rdy;
        logic        opv;
        logic [31:0] pend;
        logic [3:0]  infl;
        logic        drn;
        logic        werr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid;
    logic        iss_ready;
    logic [4:0]  iss_rs1;
    logic [4:0]  iss_rs2;
    logic [4:0]  iss_rd;
    logic        iss_use1;
    logic        iss_use2;
    logic        iss_wr;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [4:0]  rf_rs1;
    logic [4:0]  rf_rs2;
    logic        op_valid;
    logic [31:0] pending;
    logic [3:0]  inflight;
    logic        drain_req;
    logic        drained;
    logic        wb_err;
`ifdef REGS_SB_FWD_EN
    logic        fwd1;
    logic        fwd2;
`endif

    int   errs   = 0;
    int   checks = 0;
    vec_t tab_a[32];
    vec_t tab_b[32];
    int   na = 0;
    int   nb = 0;

    always #5 clk = ~clk;

    regs_scoreboard #(.MAX_INFLIGHT(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_ready (iss_ready),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_rd    (iss_rd),
        .iss_use1  (iss_use1),
        .iss_use2  (iss_use2),
        .iss_wr    (iss_wr),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .rf_rs1    (rf_rs1),
        .rf_rs2    (rf_rs2),
        .op_valid  (op_valid),
        .pending   (pending),
        .inflight  (inflight),
        .drain_req (drain_req),
        .drained   (drained),
`ifdef REGS_SB_FWD_EN
        .fwd1      (fwd1),
        .fwd2      (fwd2),
`endif
        .wb_err    (wb_err)
    );

    function automatic vec_t mk(input logic rst_i, input logic iv, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                                input logic u2, input logic wr, input logic wbv,
                                input logic [4:0] wbrd, input logic drq, input logic rdy,
                                input logic opv, input logic [31:0] pend,
                                input logic [3:0] infl, input logic drn, input logic werr);
        return '{rst_i, iv, rs1, rs2, rd, u1, u2, wr, wbv, wbrd, drq,
                 rdy, opv, pend, infl, drn, werr};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst       = v.rst;
        iss_valid = v.iv;
        iss_rs1   = v.rs1;
        iss_rs2   = v.rs2;
        iss_rd    = v.rd;
        iss_use1  = v.u1;
        iss_use2  = v.u2;
        iss_wr    = v.wr;
        wb_valid  = v.wbv;
        wb_rd     = v.wbrd;
        drain_req = v.drq;
    endtask

    // Inputs are applied just after a rising edge, outputs checked at the falling edge.
    task automatic run_row(input string tag, input int idx, input vec_t v);
        drive(v);
        @(negedge clk);
        chk($sformatf("%s%0d.ready", tag, idx),    32'(iss_ready), 32'(v.rdy));
        chk($sformatf("%s%0d.op_valid", tag, idx), 32'(op_valid),  32'(v.opv));
        chk($sformatf("%s%0d.pending", tag, idx),  pending,        v.pend);
        chk($sformatf("%s%0d.inflight", tag, idx), 32'(inflight),  32'(v.infl));
        chk($sformatf("%s%0d.drained", tag, idx),  32'(drained),   32'(v.drn));
        chk($sformatf("%s%0d.wb_err", tag, idx),   32'(wb_err),    32'(v.werr));
        chk($sformatf("%s%0d.rf_rs1", tag, idx),   32'(rf_rs1),    32'(v.rs1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                rst iv rs1    rs2    rd     u1 u2 wr wbv wbrd  drq  rdy opv pend          infl  drn werr
        tab_a[na++] = mk(L, H, 5'd0,  5'd0,  5'd5,  L, L, H, L, 5'd0,  L,   H, L, 32'h0,        4'd0, L, L);
        tab_a[na++] = mk(L, H, 5'd5,  5'd0,  5'd0,  H, L, L, L, 5'd0,  L,   L, H, 32'h20,       4'd1, L, L);
        tab_a[na++] = mk(L, H, 5'd5,  5'd0,  5'd0,  H, L, L, H, 5'd5,  L,   L, L, 32'h20,       4'd1, L, L);
        tab_a[na++] = mk(L, H, 5'd5,  5'd0,  5'd0,  H, L, L, L, 5'd0,  L,   H, L, 32'h0,        4'd0, L, L);
        tab_a[na++] = mk(L, L, 5'd0,  5'd0,  5'd0,  L, L, L, L, 5'd0,  L,   H, H, 32'h0,        4'd0, L, L);
        tab_a[na++] = mk(L, H, 5'd0,  5'd0,  5'd0,  L, L, H, L, 5'd0,  L,   H, L, 32'h0,        4'd0, L, L);
        tab_a[na++] = mk(L, H, 5'd0,  5'd0,  5'd0,  L, L, H, L, 5'd0,  L,   H, H, 32'h0,        4'd0, L, L);
        tab_a[na++] = mk(L, H, 5'd0,  5'd0,  5'd0,  L, L, H, L, 5'd0,  L,   H, H, 32'h0,        4'd0, L, L);
        tab_a[na++] = mk(L, H, 5'd0,  5'd0,  5'd0,  L, L, H, L, 5'd0,  L,   H, H, 32'h0,        4'd0, L, L);
        tab_a[na++] = mk(L, H, 5'd0,  5'd0,  5'd1,  L, L, H, L, 5'd0,  L,   H, H, 32'h0,        4'd0, L, L);
        tab_a[na++] = mk(L, H, 5'd0,  5'd0,  5'd2,  L, L, H, L, 5'd0,  L,   H, H, 32'h2,        4'd1, L, L);
        tab_a[na++] = mk(L, H, 5'd0,  5'd0,  5'd3,  L, L, H, L, 5'd0,  L,   H, H, 32'h6,        4'd2, L, L);
        tab_a[na++] = mk(L, H, 5'd0,  5'd0,  5'd4,  L, L, H, L, 5'd0,  L,   H, H, 32'hE,        4'd3, L, L);
        tab_a[na++] = mk(L, H, 5'd0,  5'd0,  5'd6,  L, L, H, L, 5'd0,  L,   L, H, 32'h1E,       4'd4, L, L);
        tab_a[na++] = mk(L, H, 5'd0,  5'd0,  5'd6,  L, L, H, H, 5'd2,  L,   L, L, 32'h1E,       4'd4, L, L);
        tab_a[na++] = mk(L, H, 5'd0,  5'd0,  5'd6,  L, L, H, L, 5'd0,  L,   H, L, 32'h1A,       4'd3, L, L);
        tab_a[na++] = mk(L, L, 5'd0,  5'd0,  5'd0,  L, L, L, H, 5'd9,  L,   H, H, 32'h5A,       4'd4, L, L);
        tab_a[na++] = mk(L, L, 5'd0,  5'd0,  5'd0,  L, L, L, L, 5'd0,  L,   H, L, 32'h5A,       4'd4, L, H);
        tab_a[na++] = mk(L, H, 5'd0,  5'd0,  5'd3,  L, L, H, L, 5'd0,  L,   L, L, 32'h5A,       4'd4, L, L);
        tab_a[na++] = mk(L, H, 5'd0,  5'd4,  5'd0,  L, H, L, L, 5'd0,  L,   L, L, 32'h5A,       4'd4, L, L);
        tab_a[na++] = mk(L, H, 5'd0,  5'd0,  5'd0,  H, H, H, L, 5'd0,  L,   H, L, 32'h5A,       4'd4, L, L);
        tab_a[na++] = mk(L, L, 5'd0,  5'd0,  5'd0,  L, L, L, H, 5'd1,  L,   H, H, 32'h5A,       4'd4, L, L);
        tab_a[na++] = mk(L, L, 5'd0,  5'd0,  5'd0,  L, L, L, H, 5'd3,  L,   H, L, 32'h58,       4'd3, L, L);
        tab_a[na++] = mk(L, L, 5'd0,  5'd0,  5'd0,  L, L, L, H, 5'd4,  L,   H, L, 32'h50,       4'd2, L, L);
        tab_a[na++] = mk(L, H, 5'd0,  5'd0,  5'd7,  L, L, H, H, 5'd6,  L,   H, L, 32'h40,       4'd1, L, L);

        // Drain / quiesce, drain_req dropped mid-drain, then reset taken while draining.
        tab_b[nb++] = mk(L, H, 5'd0,  5'd0,  5'd10, L, L, H, L, 5'd0,  L,   H, L, 32'h0,        4'd0, L, L);
        tab_b[nb++] = mk(L, H, 5'd0,  5'd0,  5'd11, L, L, H, L, 5'd0,  L,   H, H, 32'h400,      4'd1, L, L);
        tab_b[nb++] = mk(L, H, 5'd0,  5'd0,  5'd12, L, L, H, L, 5'd0,  L,   H, H, 32'hC00,      4'd2, L, L);
        tab_b[nb++] = mk(L, L, 5'd0,  5'd0,  5'd0,  L, L, L, L, 5'd0,  H,   H, H, 32'h1C00,     4'd3, L, L);
        tab_b[nb++] = mk(L, H, 5'd0,  5'd0,  5'd13, L, L, H, H, 5'd10, H,   L, L, 32'h1C00,     4'd3, L, L);
        tab_b[nb++] = mk(L, H, 5'd0,  5'd0,  5'd13, L, L, H, H, 5'd11, H,   L, L, 32'h1800,     4'd2, L, L);
        tab_b[nb++] = mk(L, L, 5'd0,  5'd0,  5'd0,  L, L, L, H, 5'd12, L,   L, L, 32'h1000,     4'd1, L, L);
        tab_b[nb++] = mk(L, H, 5'd0,  5'd0,  5'd13, L, L, H, L, 5'd0,  L,   L, L, 32'h0,        4'd0, L, L);
        tab_b[nb++] = mk(L, L, 5'd0,  5'd0,  5'd0,  L, L, L, L, 5'd0,  H,   L, L, 32'h0,        4'd0, H, L);
        tab_b[nb++] = mk(L, L, 5'd0,  5'd0,  5'd0,  L, L, L, L, 5'd0,  L,   L, L, 32'h0,        4'd0, H, L);
        tab_b[nb++] = mk(L, H, 5'd0,  5'd0,  5'd13, L, L, H, L, 5'd0,  L,   H, L, 32'h0,        4'd0, L, L);
        tab_b[nb++] = mk(L, L, 5'd0,  5'd0,  5'd0,  L, L, L, L, 5'd0,  H,   H, H, 32'h2000,     4'd1, L, L);
        tab_b[nb++] = mk(L, H, 5'd0,  5'd0,  5'd14, L, L, H, L, 5'd0,  H,   L, L, 32'h2000,     4'd1, L, L);
        tab_b[nb++] = mk(H, L, 5'd0,  5'd0,  5'd0,  L, L, L, L, 5'd0,  L,   L, L, 32'h2000,     4'd1, L, L);
        tab_b[nb++] = mk(L, H, 5'd0,  5'd0,  5'd14, L, L, H, L, 5'd0,  L,   H, L, 32'h0,        4'd0, L, L);

        drive(mk(H, L, 5'd0, 5'd0, 5'd0, L, L, L, L, 5'd0, L, L, L, 32'h0, 4'd0, L, L));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset.ready",    32'(iss_ready), 32'h0);
        chk("reset.pending",  pending,        32'h0);
        chk("reset.inflight", 32'(inflight),  32'h0);
        chk("reset.op_valid", 32'(op_valid),  32'h0);
        chk("reset.wb_err",   32'(wb_err),    32'h0);
        chk("reset.drained",  32'(drained),   32'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < na; i++) run_row("a", i, tab_a[i]);

        // Writeback of r7 in the same cycle as an issue that reads r7 via rs2.
        drive(mk(L, H, 5'd0, 5'd7, 5'd0, L, H, L, H, 5'd7, L, L, L, 32'h0, 4'd0, L, L));
        @(negedge clk);
        chk("fwd.h1.ready",    32'(iss_ready), 32'(c_FWD));
        chk("fwd.h1.pending",  pending,        32'h80);
        chk("fwd.h1.rf_rs2",   32'(rf_rs2),    32'd7);
        @(posedge clk);
        #1;
        drive(mk(L, H, 5'd0, 5'd7, 5'd0, L, H, L, L, 5'd0, L, L, L, 32'h0, 4'd0, L, L));
        @(negedge clk);
        chk("fwd.h2.ready",    32'(iss_ready), 32'h1);
        chk("fwd.h2.op_valid", 32'(op_valid),  32'(c_FWD));
        chk("fwd.h2.pending",  pending,        32'h0);
        chk("fwd.h2.inflight", 32'(inflight),  32'h0);
        chk("fwd.h2.wb_err",   32'(wb_err),    32'h0);
`ifdef REGS_SB_FWD_EN
        chk("fwd.h2.fwd2",     32'(fwd2),      32'h1);
        chk("fwd.h2.fwd1",     32'(fwd1),      32'h0);
`endif
        @(posedge clk);
        #1;
        drive(mk(L, L, 5'd0, 5'd0, 5'd0, L, L, L, L, 5'd0, L, L, L, 32'h0, 4'd0, L, L));
        @(negedge clk);
        chk("fwd.h3.op_valid", 32'(op_valid),  32'h1);
`ifdef REGS_SB_FWD_EN
        chk("fwd.h3.fwd2",     32'(fwd2),      32'h0);
`endif
        @(posedge clk);
        #1;

        for (int i = 0; i < nb; i++) run_row("b", i, tab_b[i]);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule : tb_regs_scoreboard
`default_nettype wire
